// File: rtl/mem_stage_if.sv
// Bus between the MEM stage and the data memory: request from the master side,
// ready/read-data response from the slave side.
interface mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM and MEM/WB registers, data-memory handshake with a
// bounded wait, load extension, store byte lanes and sticky error flags.
module mem_stage #(
   parameter int MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ALU_OUT_EX,
   input  logic [31:0] REG_DATA2_EX_FINAL,
   input  logic [2:0]  FUNCT3_EX,
   input  logic [4:0]  RD_EX,
   input  logic        RegWrite_EX,
   input  logic        MemtoReg_EX,
   input  logic        MemRead_EX,
   input  logic        MemWrite_EX,
   mem_stage_if.master dmem,
   output logic [31:0] ALU_OUT_MEM,
   output logic [4:0]  RD_MEM,
   output logic        RegWrite_MEM,
   output logic [31:0] ALU_DATA_WB,
   output logic [31:0] MEM_DATA_WB,
   output logic [4:0]  RD_WB,
   output logic        RegWrite_WB,
   output logic        MemtoReg_WB,
   output logic        STALL,
   output logic [1:0]  MEM_ERR
);
   localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_e;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic        rw;
      logic        m2r;
      logic        mr;
      logic        mw;
   } exm_t;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] mem;
      logic [4:0]  rd;
      logic        rw;
      logic        m2r;
   } wb_t;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    err_q, err_d;
   exm_t          exm_q, exm_d;
   wb_t           wb_q, wb_d;

   logic        mem_op, misal, req, stall, wb_cap;
   logic [1:0]  lane;
   logic [31:0] rshift, load_data, st_data;
   logic [3:0]  be;

   assign lane   = exm_q.alu[1:0];
   assign mem_op = exm_q.mr | exm_q.mw;
   // f3[1:0]: 00 byte, 01 half, 1x word
   assign misal  = mem_op & ((exm_q.f3[1:0] == 2'b01 & lane[0]) | (exm_q.f3[1] & lane != 2'b00));

   always_comb begin
      rshift = dmem.dmem_rdata >> {lane, 3'b000};
      case (exm_q.f3)
         3'b000:  load_data = {{24{rshift[7]}}, rshift[7:0]};
         3'b001:  load_data = {{16{rshift[15]}}, rshift[15:0]};
         3'b100:  load_data = {24'b0, rshift[7:0]};
         3'b101:  load_data = {16'b0, rshift[15:0]};
         default: load_data = dmem.dmem_rdata;
      endcase
      // A load that also has MemWrite set behaves as a store and returns nothing.
      if (!exm_q.mr || exm_q.mw) load_data = '0;

      case (exm_q.f3[1:0])
         2'b00:   begin be = 4'b0001 << lane; st_data = {4{exm_q.wdata[7:0]}};  end
         2'b01:   begin be = 4'b0011 << lane; st_data = {2{exm_q.wdata[15:0]}}; end
         default: begin be = 4'b1111;         st_data = exm_q.wdata;           end
      endcase
      if (!exm_q.mw) be = 4'b1111;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      req     = 1'b0;
      stall   = 1'b0;
      wb_cap  = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (mem_op) begin
               if (misal) begin
                  err_d[0] = 1'b1;
                  wb_cap   = 1'b0;
               end else begin
                  req = 1'b1;
                  if (!dmem.dmem_ready) begin
                     stall   = 1'b1;
                     state_d = S_WAIT;
                     cnt_d   = '0;
                  end
               end
            end
         end
         S_WAIT: begin
            req = 1'b1;
            if (dmem.dmem_ready) begin
               state_d = S_IDLE;
            end else begin
               stall = 1'b1;
               if (cnt_q == LAST) begin
                  state_d  = S_DRAIN;
                  err_d[1] = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_DRAIN: begin
            wb_cap  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      exm_d = exm_q;
      if (!stall) begin
         exm_d.alu   = ALU_OUT_EX;
         exm_d.wdata = REG_DATA2_EX_FINAL;
         exm_d.f3    = FUNCT3_EX;
         exm_d.rd    = RD_EX;
         exm_d.rw    = RegWrite_EX;
         exm_d.m2r   = MemtoReg_EX;
         exm_d.mr    = MemRead_EX;
         exm_d.mw    = MemWrite_EX;
      end

      // Bubbles keep the old WB data and only kill the register write.
      wb_d = wb_q;
      if (stall || !wb_cap) begin
         wb_d.rw = 1'b0;
      end else begin
         wb_d.alu = exm_q.alu;
         wb_d.mem = load_data;
         wb_d.rd  = exm_q.rd;
         wb_d.rw  = exm_q.rw;
         wb_d.m2r = exm_q.m2r;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         err_q   <= '0;
         exm_q   <= '0;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         exm_q   <= exm_d;
         wb_q    <= wb_d;
      end
   end

   assign dmem.dmem_req   = req;
   assign dmem.dmem_we    = exm_q.mw;
   assign dmem.dmem_addr  = {exm_q.alu[31:2], 2'b00};
   assign dmem.dmem_wdata = st_data;
   assign dmem.dmem_be    = be;

   assign ALU_OUT_MEM  = exm_q.alu;
   assign RD_MEM       = exm_q.rd;
   assign RegWrite_MEM = exm_q.rw;
   assign ALU_DATA_WB  = wb_q.alu;
   assign MEM_DATA_WB  = wb_q.mem;
   assign RD_WB        = wb_q.rd;
   assign RegWrite_WB  = wb_q.rw;
   assign MemtoReg_WB  = wb_q.m2r;
   assign STALL        = stall;
   assign MEM_ERR      = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: an instruction-level model predicts every
// output each cycle; a few directed sequences pin known values.
module tb_mem_stage;
   localparam int MW = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [31:0] ALU_OUT_EX, REG_DATA2_EX_FINAL;
   logic [2:0]  FUNCT3_EX;
   logic [4:0]  RD_EX;
   logic        RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX;
   logic [31:0] ALU_OUT_MEM, ALU_DATA_WB, MEM_DATA_WB;
   logic [4:0]  RD_MEM, RD_WB;
   logic        RegWrite_MEM, RegWrite_WB, MemtoReg_WB, STALL;
   logic [1:0]  MEM_ERR;

   mem_stage_if bus();

   mem_stage #(.MAX_WAIT(MW)) dut (
      .clk(clk), .rst_n(rst_n),
      .ALU_OUT_EX(ALU_OUT_EX), .REG_DATA2_EX_FINAL(REG_DATA2_EX_FINAL),
      .FUNCT3_EX(FUNCT3_EX), .RD_EX(RD_EX),
      .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX),
      .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
      .dmem(bus),
      .ALU_OUT_MEM(ALU_OUT_MEM), .RD_MEM(RD_MEM), .RegWrite_MEM(RegWrite_MEM),
      .ALU_DATA_WB(ALU_DATA_WB), .MEM_DATA_WB(MEM_DATA_WB), .RD_WB(RD_WB),
      .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB),
      .STALL(STALL), .MEM_ERR(MEM_ERR)
   );

   // wt = cycles the memory withholds ready; rdv = data returned with ready
   typedef struct {
      logic [31:0] alu, wd, rdv;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic        rw, m2r, mr, mw;
      int          wt;
   } ins_t;

   int vec = 0, bad = 0, stall_cnt = 0;

   ins_t        cur, m_exm;
   int          m_w;
   bit          m_drain;
   logic [1:0]  m_err;
   logic [31:0] m_alu_wb, m_mem_wb;
   logic [4:0]  m_rd_wb;
   logic        m_rw_wb, m_m2r_wb;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic ins_t mk(logic [31:0] alu, logic [31:0] wd, logic [2:0] f3, logic [4:0] rd,
                               logic rw, logic mr, logic mw, int wt, logic [31:0] rdv);
      ins_t i;
      i.alu = alu; i.wd = wd; i.f3 = f3; i.rd = rd; i.rw = rw;
      i.mr = mr; i.mw = mw; i.m2r = mr; i.wt = wt; i.rdv = rdv;
      return i;
   endfunction

   function automatic ins_t nop();
      return mk(32'h0, 32'h0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
   endfunction

   function automatic ins_t rnd();
      ins_t i;
      logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      int k = $urandom_range(0, 9);
      i.alu = $urandom; i.wd = $urandom; i.rdv = $urandom;
      i.rd  = 5'($urandom); i.rw = 1'($urandom);
      i.mr  = (k >= 4 && k <= 6) || k == 9;
      i.mw  = (k >= 7);
      i.m2r = i.mr;
      i.f3  = i.mw ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 4)];
      if ((i.mr || i.mw) && $urandom_range(0, 3) != 0) i.alu[1:0] = 2'b00;
      i.wt  = ($urandom_range(0, 9) == 0) ? MW - 1 + $urandom_range(0, 2) : $urandom_range(0, 3);
      return i;
   endfunction

   task automatic drive(input ins_t i);
      cur = i;
      ALU_OUT_EX = i.alu; REG_DATA2_EX_FINAL = i.wd; FUNCT3_EX = i.f3; RD_EX = i.rd;
      RegWrite_EX = i.rw; MemtoReg_EX = i.m2r; MemRead_EX = i.mr; MemWrite_EX = i.mw;
   endtask

   task automatic model_reset();
      m_exm = nop(); m_w = 0; m_drain = 0; m_err = 2'b00;
      m_alu_wb = '0; m_mem_wb = '0; m_rd_wb = '0; m_rw_wb = 1'b0; m_m2r_wb = 1'b0;
   endtask

   // One clock: drive the memory response, compare every output against the
   // model, advance the model. acc = the driven EX instruction gets latched.
   task automatic tick(output bit acc);
      ins_t I;
      bit mem, mis, ereq, rdy;
      int a;
      logic [31:0] rdv, ld;
      @(negedge clk);
      I    = m_exm;
      a    = int'(I.alu[1:0]);
      mem  = I.mr || I.mw;
      mis  = mem && ((I.f3[1:0] == 2'd1 && a % 2 == 1) || (I.f3[1] && a != 0));
      ereq = !m_drain && mem && !mis;
      rdy  = ereq ? (m_w >= I.wt) : ($urandom_range(0, 1) == 1);
      rdv  = (ereq && rdy) ? I.rdv : $urandom;
      bus.dmem_ready = rdy;
      bus.dmem_rdata = rdv;
      #1;
      if (STALL === 1'b1) stall_cnt++;
      chk("STALL", STALL, ereq && !rdy);
      chk("dmem_req", bus.dmem_req, ereq);
      if (ereq) begin
         chk("dmem_addr", bus.dmem_addr, I.alu & 32'hFFFF_FFFC);
         chk("dmem_we", bus.dmem_we, I.mw);
         if (I.mw) begin
            case (I.f3[1:0])
               2'd0: begin
                  chk("dmem_be", bus.dmem_be, 32'(1 << a));
                  chk("dmem_wdata", bus.dmem_wdata, 32'h0101_0101 * I.wd[7:0]);
               end
               2'd1: begin
                  chk("dmem_be", bus.dmem_be, 32'(3 << a));
                  chk("dmem_wdata", bus.dmem_wdata, 32'h0001_0001 * I.wd[15:0]);
               end
               default: begin
                  chk("dmem_be", bus.dmem_be, 32'hF);
                  chk("dmem_wdata", bus.dmem_wdata, I.wd);
               end
            endcase
         end else begin
            chk("dmem_be", bus.dmem_be, 32'hF);
         end
      end
      chk("ALU_OUT_MEM", ALU_OUT_MEM, I.alu);
      chk("RD_MEM", RD_MEM, I.rd);
      chk("RegWrite_MEM", RegWrite_MEM, I.rw);
      chk("ALU_DATA_WB", ALU_DATA_WB, m_alu_wb);
      chk("MEM_DATA_WB", MEM_DATA_WB, m_mem_wb);
      chk("RD_WB", RD_WB, m_rd_wb);
      chk("RegWrite_WB", RegWrite_WB, m_rw_wb);
      chk("MemtoReg_WB", MemtoReg_WB, m_m2r_wb);
      chk("MEM_ERR", MEM_ERR, m_err);

      case (I.f3)
         3'd0:    ld = 32'($signed(rdv[8*a +: 8]));
         3'd1:    ld = 32'($signed(rdv[8*a +: 16]));
         3'd4:    ld = 32'(rdv[8*a +: 8]);
         3'd5:    ld = 32'(rdv[8*a +: 16]);
         default: ld = rdv;
      endcase
      acc = 1'b1;
      if (m_drain) begin
         m_rw_wb = 1'b0; m_drain = 0;
      end else if (mem && mis) begin
         m_err[0] = 1'b1; m_rw_wb = 1'b0;
      end else if (ereq && !rdy) begin
         acc = 1'b0; m_rw_wb = 1'b0;
         if (m_w == MW) begin m_err[1] = 1'b1; m_drain = 1; m_w = 0; end
         else m_w++;
      end else begin
         m_w = 0;
         m_alu_wb = I.alu; m_rd_wb = I.rd; m_rw_wb = I.rw; m_m2r_wb = I.m2r;
         m_mem_wb = (I.mr && !I.mw) ? ld : 32'h0;
      end
      if (acc) m_exm = cur;
      @(posedge clk);
      #1;
   endtask

   // Present i on the EX inputs and clock until the stage latches it.
   task automatic run(input ins_t i);
      bit acc;
      int n = 0;
      drive(i);
      do begin
         tick(acc);
         n++;
      end while (!acc && n < 100);
      if (!acc) begin
         vec++; bad++;
         $display("FAIL accept-timeout: instruction not latched after %0d cycles", n);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit acc;
      int s;
      rst_n = 1'b0;
      drive(nop());
      bus.dmem_ready = 1'b0;
      bus.dmem_rdata = '0;
      model_reset();
      @(posedge clk); #1;
      chk("rst STALL", STALL, 0);
      chk("rst dmem_req", bus.dmem_req, 0);
      chk("rst ALU_OUT_MEM", ALU_OUT_MEM, 0);
      chk("rst RegWrite_WB", RegWrite_WB, 0);
      chk("rst MEM_ERR", MEM_ERR, 0);
      rst_n = 1'b1;

      // ADD result 0x10 to x5
      run(mk(32'h10, 32'h0, 3'd0, 5'd5, 1'b1, 1'b0, 1'b0, 0, 32'h0));
      chk("add ALU_OUT_MEM", ALU_OUT_MEM, 32'h10);
      chk("add RD_MEM", RD_MEM, 5);
      run(nop());
      chk("add ALU_DATA_WB", ALU_DATA_WB, 32'h10);
      chk("add RD_WB", RD_WB, 5);
      chk("add RegWrite_WB", RegWrite_WB, 1);

      // LB / LBU at 0x103, zero-wait
      s = stall_cnt;
      run(mk(32'h103, 32'h0, 3'd0, 5'd7, 1'b1, 1'b1, 1'b0, 0, 32'h80FF_0000));
      run(nop());
      chk("lb MEM_DATA_WB", MEM_DATA_WB, 32'hFFFF_FF80);
      chk("lb stall cycles", stall_cnt - s, 0);
      run(mk(32'h103, 32'h0, 3'd4, 5'd7, 1'b1, 1'b1, 1'b0, 0, 32'h80FF_0000));
      run(nop());
      chk("lbu MEM_DATA_WB", MEM_DATA_WB, 32'h0000_0080);

      // SH at 0x202
      run(mk(32'h202, 32'h1234_ABCD, 3'd1, 5'd0, 1'b0, 1'b0, 1'b1, 0, 32'h0));
      chk("sh dmem_be", bus.dmem_be, 32'b1100);
      chk("sh dmem_wdata", bus.dmem_wdata, 32'hABCD_ABCD);
      chk("sh dmem_we", bus.dmem_we, 1);
      run(nop());

      // LW, ready after 3 cycles
      s = stall_cnt;
      run(mk(32'h300, 32'h0, 3'd2, 5'd9, 1'b1, 1'b1, 1'b0, 3, 32'hCAFE_F00D));
      run(nop());
      chk("lw3 stall cycles", stall_cnt - s, 3);
      chk("lw3 MEM_DATA_WB", MEM_DATA_WB, 32'hCAFE_F00D);
      chk("lw3 MEM_ERR", MEM_ERR, 2'b00);

      // LW that never sees ready
      s = stall_cnt;
      run(mk(32'h400, 32'h0, 3'd2, 5'd9, 1'b1, 1'b1, 1'b0, 9999, 32'h0));
      run(nop());
      chk("timeout stall cycles", stall_cnt - s, MW + 1);
      chk("timeout MEM_ERR", MEM_ERR, 2'b10);
      chk("timeout RegWrite_WB", RegWrite_WB, 0);

      // misaligned LW at 0x101
      run(mk(32'h101, 32'h0, 3'd2, 5'd3, 1'b1, 1'b1, 1'b0, 0, 32'h0));
      chk("misal dmem_req", bus.dmem_req, 0);
      chk("misal STALL", STALL, 0);
      run(nop());
      chk("misal MEM_ERR", MEM_ERR, 2'b11);
      chk("misal RegWrite_WB", RegWrite_WB, 0);

      // reset in the middle of a wait
      run(mk(32'hDEAD_BEEF, 32'h0, 3'd0, 5'd6, 1'b1, 1'b0, 1'b0, 0, 32'h0));
      run(mk(32'h500, 32'h0, 3'd2, 5'd4, 1'b1, 1'b1, 1'b0, 9999, 32'h0));
      drive(nop());
      for (int k = 0; k < 3; k++) tick(acc);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("wrst dmem_req", bus.dmem_req, 0);
      chk("wrst STALL", STALL, 0);
      chk("wrst ALU_DATA_WB", ALU_DATA_WB, 0);
      chk("wrst MEM_DATA_WB", MEM_DATA_WB, 0);
      chk("wrst RD_WB", RD_WB, 0);
      chk("wrst RegWrite_WB", RegWrite_WB, 0);
      chk("wrst MemtoReg_WB", MemtoReg_WB, 0);
      chk("wrst MEM_ERR", MEM_ERR, 0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int n = 0; n < 400; n++) run(rnd());
      run(nop());
      run(nop());

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16, max cycles a data-memory request may wait for dmem_ready.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ALU_OUT_EX  input  32  EX result / memory address.
REQ-005 SHALL have port REG_DATA2_EX_FINAL  input  32  forwarded store data.
REQ-006 SHALL have ports FUNCT3_EX  input  3, RD_EX  input  5, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX  input  1 each; EX control.
REQ-007 SHALL have ports dmem_req, dmem_we  output  1, dmem_addr, dmem_wdata  output  32, dmem_be  output  4; memory request.
REQ-008 SHALL have ports dmem_ready  input  1, dmem_rdata  input  32; memory response.
REQ-009 SHALL have ports ALU_OUT_MEM  output  32, RD_MEM  output  5, RegWrite_MEM  output  1; EX/MEM contents for forwarding.
REQ-010 SHALL have ports ALU_DATA_WB, MEM_DATA_WB  output  32, RD_WB  output  5, RegWrite_WB, MemtoReg_WB  output  1; MEM/WB contents.
REQ-011 SHALL have ports STALL  output  1 (freeze IF/ID/EX), MEM_ERR  output  2 (sticky: bit0 misaligned, bit1 timeout).

Function
REQ-012 SHALL latch all EX inputs into the EX/MEM register each cycle STALL=0; hold it when STALL=1.
REQ-013 SHALL drive ALU_OUT_MEM, RD_MEM, RegWrite_MEM directly from the EX/MEM register.
REQ-014 SHALL implement FSM IDLE, WAIT, ERR_DRAIN; memory op = MemRead|MemWrite in EX/MEM register.
REQ-015 IDLE with aligned memory op SHALL assert dmem_req combinationally; dmem_ready same cycle -> complete, no stall, stay IDLE.
REQ-016 IDLE with aligned memory op and dmem_ready=0 SHALL assert STALL, go WAIT, clear wait counter.
REQ-017 WAIT SHALL keep dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be stable, STALL=1, counter +1 per cycle; dmem_ready=1 -> complete, STALL=0, IDLE.
REQ-018 WAIT with counter = MAX_WAIT-1 and dmem_ready=0 SHALL go ERR_DRAIN, set MEM_ERR[1], drop dmem_req.
REQ-019 ERR_DRAIN SHALL last one cycle: STALL=0, write a bubble (RegWrite_WB=0) into MEM/WB, return IDLE.
REQ-020 dmem_addr SHALL be {ALU_OUT_MEM[31:2],2'b00}; dmem_we = MemWrite.
REQ-021 Stores SHALL set dmem_be: SB 0001<<a[1:0], SH 0011<<a[1:0], SW 1111; wdata byte replicated (SB), halfword replicated (SH), word as-is.
REQ-022 Loads SHALL select by a[1:0] and extend: LB/LH sign, LBU/LHU zero, LW none; dmem_be=1111.
REQ-023 Misaligned (LH/LHU/SH with a[0]=1; LW/SW with a[1:0]!=0) SHALL issue no request, set MEM_ERR[0], pass bubble to WB, no stall.
REQ-024 On non-stall cycles MEM/WB SHALL capture ALU_OUT_MEM, extended load data, RD, RegWrite, MemtoReg; during STALL=1 it SHALL load a bubble (RegWrite_WB=0, data held).
REQ-025 Non-memory instruction latency SHALL be 1 cycle EX/MEM -> MEM/WB; zero-wait memory op likewise 1 cycle.
REQ-026 Memory op with MemRead and MemWrite both set SHALL be treated as store.
REQ-027 MEM_ERR bits SHALL remain set until reset.

Reset
REQ-028 rst_n=0 SHALL immediately (asynchronously) clear FSM to IDLE, counter, EX/MEM and MEM/WB registers, MEM_ERR; dmem_req=0, STALL=0.
REQ-029 Reset during WAIT SHALL abandon the request; no WB write after release.
REQ-030 First EX/MEM capture SHALL occur on the first rising edge with rst_n=1.

Verification
REQ-031 ADD result 0x0000_0010, RD=5 -> next cycle ALU_OUT_MEM=0x10; one cycle later ALU_DATA_WB=0x10, RD_WB=5, RegWrite_WB=1.
REQ-032 LB addr 0x103, dmem_rdata 0x80FF_0000, ready same cycle -> MEM_DATA_WB=0xFFFF_FF80, STALL never 1; LBU -> 0x0000_0080.
REQ-033 SH addr 0x202, data 0x1234_ABCD -> dmem_be=1100, dmem_wdata=0xABCD_ABCD, dmem_we=1.
REQ-034 LW, dmem_ready after 3 cycles -> STALL high exactly 3 cycles, outputs stable, one WB write, MEM_ERR=00.
REQ-035 LW with dmem_ready=0 for MAX_WAIT cycles -> MEM_ERR=10, one bubble, STALL drops; LW addr 0x101 -> no dmem_req, MEM_ERR[0]=1.
REQ-036 rst_n low mid-WAIT -> dmem_req=0, STALL=0 same cycle, all WB outputs 0.
